// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, FSM states,
// ALU operations and the instruction classifier used by EXEC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic    rtype;
    logic    addi;
    logic    lw;
    logic    sw;
    logic    beq;
    logic    jmp;
    logic    bad;
    alu_op_e op;
  } dec_t;

  // Unsupported opcodes and R-type functs both land on bad.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d    = '0;
    d.op = ALU_ADD;
    case (ir[31:26])
      OP_RTYPE: begin
        d.rtype = 1'b1;
        case (ir[5:0])
          FN_ADD:  d.op = ALU_ADD;
          FN_SUB:  d.op = ALU_SUB;
          FN_AND:  d.op = ALU_AND;
          FN_OR:   d.op = ALU_OR;
          FN_SLT:  d.op = ALU_SLT;
          default: d.bad = 1'b1;
        endcase
      end
      OP_ADDI: d.addi = 1'b1;
      OP_LW:   d.lw   = 1'b1;
      OP_SW:   d.sw   = 1'b1;
      OP_BEQ:  d.beq  = 1'b1;
      OP_J:    d.jmp  = 1'b1;
      default: d.bad  = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two async read ports, one debug read port, one
// synchronous write port; $0 always reads zero and ignores writes.
module mc_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] dbg_rdata
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) regs[waddr] <= wdata;
  end

  // Reads see the pre-write value during a write cycle.
  assign rdata_a   = (raddr_a   == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b   = (raddr_b   == 5'd0) ? '0 : regs[raddr_b];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS-subset core: one shared ALU, one req/ready memory port,
// wait-state timeout, misalignment and illegal-instruction traps.
module multicycle_mips_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int          MEM_TIMEOUT     = 16,
  parameter int          TIMEOUT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic        retire,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  state_e               state, state_nx;
  logic [31:0]          pc, ir, a, b, imm, alu_out, mdr;
  logic [31:0]          alu_b, alu_res, rs_data, rt_data, rf_wdata;
  logic [4:0]           rf_waddr;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 req_en, rf_we, done, timeout_hit, misaligned, fetch_req;
  dec_t                 dec;

  assign dec = decode(ir);

  // req_en keeps the port quiet while reset is held; fetch starts on the
  // first clock after release.
  assign fetch_req = (state == FETCH) && req_en;
  assign mem_req   = fetch_req || (state == MEM);
  assign mem_we    = (state == MEM) && dec.sw;
  assign mem_addr  = fetch_req ? pc : (state == MEM) ? alu_out : '0;
  assign mem_wdata = mem_we ? b : '0;
  assign done      = mem_req && mem_ready;
  assign pc_out    = pc;

  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ready &&
                       (wait_cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));

  assign alu_b = dec.rtype ? b : imm;

  always_comb begin
    alu_res = a + alu_b;
    case (dec.op)
      ALU_SUB: alu_res = a - alu_b;
      ALU_AND: alu_res = a & alu_b;
      ALU_OR:  alu_res = a | alu_b;
      ALU_SLT: alu_res = {31'b0, $signed(a) < $signed(alu_b)};
      default: ;
    endcase
  end

  assign misaligned = (dec.lw || dec.sw) && (alu_res[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    rf_we    = 1'b0;
    case (state)
      FETCH: begin
        if (timeout_hit) state_nx = HALT;
        else if (done)   state_nx = DECODE;
      end
      DECODE: state_nx = EXEC;
      EXEC: begin
        if (dec.bad) begin
          if (HALT_ON_ILLEGAL) state_nx = HALT;
          else begin
            retire   = 1'b1;
            state_nx = FETCH;
          end
        end else if (dec.beq || dec.jmp) begin
          retire   = 1'b1;
          state_nx = FETCH;
        end else if (dec.lw || dec.sw) begin
          state_nx = misaligned ? HALT : MEM;
        end else begin
          state_nx = WB;
        end
      end
      MEM: begin
        if (timeout_hit) state_nx = HALT;
        else if (done) begin
          if (dec.sw) begin
            retire   = 1'b1;
            state_nx = FETCH;
          end else begin
            state_nx = WB;
          end
        end
      end
      WB: begin
        rf_we    = 1'b1;
        retire   = 1'b1;
        state_nx = FETCH;
      end
      HALT:    ;
      default: state_nx = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      imm      <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      wait_cnt <= '0;
      req_en   <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      req_en <= 1'b1;
      if (mem_req) wait_cnt <= mem_ready ? '0 : wait_cnt + TIMEOUT_W'(1);
      if (timeout_hit) begin
        bus_err <= 1'b1;
        halted  <= 1'b1;
      end
      case (state)
        FETCH: if (done) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a   <= rs_data;
          b   <= rt_data;
          imm <= {{16{ir[15]}}, ir[15:0]};
        end
        EXEC: begin
          alu_out <= alu_res;
          if (dec.bad) begin
            illegal <= 1'b1;
            if (HALT_ON_ILLEGAL) halted <= 1'b1;
          end else if (dec.beq && a == b) begin
            pc <= pc + {imm[29:0], 2'b00};
          end else if (dec.jmp) begin
            pc <= {pc[31:28], ir[25:0], 2'b00};
          end else if (misaligned) begin
            bus_err <= 1'b1;
            halted  <= 1'b1;
          end
        end
        MEM: if (done && dec.lw) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign rf_waddr = dec.rtype ? ir[15:11] : ir[20:16];
  assign rf_wdata = dec.lw ? mdr : alu_out;

  mc_regfile u_rf (
    .clk       (clk),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr_a   (ir[25:21]),
    .raddr_b   (ir[20:16]),
    .dbg_raddr (dbg_raddr),
    .rdata_a   (rs_data),
    .rdata_b   (rt_data),
    .dbg_rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Directed bench for multicycle_mips_core: a halting core on a wait-state
// memory model plus a non-halting core on a fixed two-word ROM.
module tb_multicycle_mips_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ready, retire, halted, illegal, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, dbg_rdata;
  logic [4:0]  dbg_raddr = 5'd0;

  logic        mem_req2, mem_we2, retire2, halted2, illegal2, bus_err2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc_out2, dbg_rdata2;

  logic [31:0] mem [64];
  logic [7:0]  wcnt = 8'd0;
  logic [7:0]  wait_cfg = 8'd0;
  logic [1:0]  ready_mode = 2'd0;  // 0: model, 1: tied high, 2: tied low
  logic        clr = 1'b0, ld_we = 1'b0;
  logic [5:0]  ld_addr = 6'd0;
  logic [31:0] ld_data = 32'd0;
  logic [31:0] prog [$];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_ready = (ready_mode == 2'd1) ||
                     (ready_mode == 2'd0 && mem_req && wcnt >= wait_cfg);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    else if (ld_we) mem[ld_addr] <= ld_data;
    else if (mem_req && mem_we && mem_ready) mem[mem_addr[7:2]] <= mem_wdata;
    if (!mem_req || mem_ready) wcnt <= 8'd0;
    else                       wcnt <= wcnt + 8'd1;
  end

  multicycle_mips_core #(.RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b1),
                         .MEM_TIMEOUT(16), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .pc_out(pc_out), .retire(retire), .halted(halted),
    .illegal(illegal), .bus_err(bus_err), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata)
  );

  // Word 0: opcode 0x3F, every other word: beq $0,$0,-1.
  assign mem_rdata2 = (mem_addr2 == 32'h0) ? 32'hFC00_0000 : 32'h1000_FFFF;

  multicycle_mips_core #(.RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b0),
                         .MEM_TIMEOUT(16), .TIMEOUT_W(8)) dut_nop (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ready(1'b1),
    .mem_rdata(mem_rdata2), .pc_out(pc_out2), .retire(retire2), .halted(halted2),
    .illegal(illegal2), .bus_err(bus_err2), .dbg_raddr(5'd0),
    .dbg_rdata(dbg_rdata2)
  );

  // Holds reset, clears and loads memory, then releases at a negedge; the
  // next negedge is cycle 1 (first request cycle).
  task automatic boot();
    rst_n = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      ld_we = 1'b1; ld_addr = i[5:0]; ld_data = prog[i];
      @(negedge clk);
    end
    ld_we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if ({mem_req, mem_we, retire, halted, illegal, bus_err} !== 6'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b want 000000", {mem_req, mem_we, retire, halted, illegal, bus_err});
    end
    n_chk++; if ({pc_out, mem_addr, mem_wdata} !== 96'h0) begin
      n_fail++; $display("FAIL rst_regs: pc %h addr %h wdata %h want 0", pc_out, mem_addr, mem_wdata);
    end
    prog.delete();
    ready_mode = 2'd1;
    boot();
    @(negedge clk);
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_first_fetch: req %b addr %h want 1 0", mem_req, mem_addr);
    end
    n_chk++; if (pc_out !== 32'h0 || {retire, halted, illegal} !== 3'b0) begin
      n_fail++; $display("FAIL rst_release: pc %h ret/halt/ill %b want 0 000", pc_out, {retire, halted, illegal});
    end
    ready_mode = 2'd0;
  endtask

  task automatic test_alu_prog();
    // addi $1,5; addi $2,7; add $3,$1,$2; addi $1,9; beq $0,$0,-1
    prog = {32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'h2001_0009, 32'h1000_FFFF};
    wait_cfg = 8'd0;
    dbg_raddr = 5'd1;
    boot();
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      n_chk++; if (retire !== (c % 4 == 0)) begin
        n_fail++; $display("FAIL alu_retire c%0d: got %b want %b", c, retire, (c % 4 == 0));
      end
      if (c == 16) begin
        n_chk++; if (dbg_rdata !== 32'd5) begin
          n_fail++; $display("FAIL wb_old_value: got %0d want 5", dbg_rdata);
        end
      end
      if (c == 17) begin
        n_chk++; if (dbg_rdata !== 32'd9) begin
          n_fail++; $display("FAIL wb_new_value: got %0d want 9", dbg_rdata);
        end
      end
    end
    dbg_raddr = 5'd2; #1;
    n_chk++; if (dbg_rdata !== 32'd7) begin
      n_fail++; $display("FAIL reg2: got %0d want 7", dbg_rdata);
    end
    dbg_raddr = 5'd3; #1;
    n_chk++; if (dbg_rdata !== 32'd12) begin
      n_fail++; $display("FAIL reg3_add: got %0d want 12", dbg_rdata);
    end
  endtask

  task automatic test_sw_lw();
    logic        er, eq, ew;
    logic [31:0] ea, ed;
    // addi $3,12; sw $3,0x80($0); lw $4,0x80($0); beq $0,$0,-1 -- 3 waits per access.
    // Timeline: addi 1-7, sw fetch 8-11 / mem 14-17, lw fetch 18-21 / mem 24-27 / wb 28.
    prog = {32'h2003_000C, 32'hAC03_0080, 32'h8C04_0080, 32'h1000_FFFF};
    wait_cfg = 8'd3;
    boot();
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      er = (c == 7) || (c == 17) || (c == 28);
      eq = 1'b1; ew = 1'b0; ed = 32'h0; ea = 32'h0;
      if (c <= 4)                 ea = 32'h0;
      else if (c >= 8 && c <= 11) ea = 32'h4;
      else if (c >= 14 && c <= 17) begin ea = 32'h80; ew = 1'b1; ed = 32'd12; end
      else if (c >= 18 && c <= 21) ea = 32'h8;
      else if (c >= 24 && c <= 27) ea = 32'h80;
      else eq = 1'b0;
      n_chk++; if (retire !== er || mem_req !== eq) begin
        n_fail++; $display("FAIL ldst_ctl c%0d: ret %b req %b want %b %b", c, retire, mem_req, er, eq);
      end
      if (eq) begin
        n_chk++; if (mem_addr !== ea || mem_we !== ew || mem_wdata !== ed) begin
          n_fail++; $display("FAIL ldst_bus c%0d: addr %h we %b wd %h want %h %b %h", c, mem_addr, mem_we, mem_wdata, ea, ew, ed);
        end
      end
    end
    @(negedge clk);
    dbg_raddr = 5'd4; #1;
    n_chk++; if (dbg_rdata !== 32'd12) begin
      n_fail++; $display("FAIL lw_result: got %0d want 12", dbg_rdata);
    end
    n_chk++; if (mem[32] !== 32'd12) begin
      n_fail++; $display("FAIL sw_memory: got %0d want 12", mem[32]);
    end
    wait_cfg = 8'd0;
  endtask

  task automatic test_beq_zero();
    logic er;
    // addi $0,$0,9 then a self-branch at 4 (fetch at 5, 8, 11, 14).
    prog = {32'h2000_0009, 32'h1000_FFFF};
    boot();
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      er = (c == 4) || (c >= 7 && (c - 7) % 3 == 0);
      n_chk++; if (retire !== er) begin
        n_fail++; $display("FAIL beq_retire c%0d: got %b want %b", c, retire, er);
      end
      if (c >= 5 && (c - 5) % 3 == 0) begin
        n_chk++; if (pc_out !== 32'h4 || mem_req !== 1'b1 || mem_addr !== 32'h4) begin
          n_fail++; $display("FAIL beq_loop c%0d: pc %h req %b addr %h want 4 1 4", c, pc_out, mem_req, mem_addr);
        end
      end
    end
    dbg_raddr = 5'd0; #1;
    n_chk++; if (dbg_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reg0_write: got %h want 0", dbg_rdata);
    end
  endtask

  task automatic test_illegal();
    int reqs;
    prog = {32'hFC00_0000};
    boot();
    repeat (3) @(negedge clk);
    n_chk++; if (illegal !== 1'b0 || retire !== 1'b0) begin
      n_fail++; $display("FAIL ill_exec: ill %b ret %b want 0 0", illegal, retire);
    end
    n_chk++; if (retire2 !== 1'b1) begin
      n_fail++; $display("FAIL ill_nop_retire: got %b want 1", retire2);
    end
    @(negedge clk);
    n_chk++; if ({illegal, halted, bus_err, mem_req} !== 4'b1100) begin
      n_fail++; $display("FAIL ill_halt: ill/halt/berr/req %b want 1100", {illegal, halted, bus_err, mem_req});
    end
    n_chk++; if ({illegal2, halted2, bus_err2, mem_req2, mem_we2} !== 5'b10010 || mem_addr2 !== 32'h4) begin
      n_fail++; $display("FAIL ill_nop_next: flags %b addr %h want 10010 4", {illegal2, halted2, bus_err2, mem_req2, mem_we2}, mem_addr2);
    end
    n_chk++; if (pc_out2 !== 32'h4 || mem_wdata2 !== 32'h0 || dbg_rdata2 !== 32'h0) begin
      n_fail++; $display("FAIL ill_nop_state: pc %h wd %h dbg %h want 4 0 0", pc_out2, mem_wdata2, dbg_rdata2);
    end
    reqs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req || pc_out !== 32'h4 || !halted) reqs++;
    end
    n_chk++; if (reqs !== 0) begin
      n_fail++; $display("FAIL ill_frozen: %0d bad cycles want 0", reqs);
    end
  endtask

  task automatic test_timeout();
    int bad;
    prog.delete();
    ready_mode = 2'd2;
    boot();
    bad = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_addr !== 32'h0 || bus_err !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) begin
      n_fail++; $display("FAIL tmo_wait: %0d bad cycles want 0", bad);
    end
    @(negedge clk);
    n_chk++; if ({bus_err, halted, illegal, mem_req} !== 4'b1100) begin
      n_fail++; $display("FAIL tmo_trap: berr/halt/ill/req %b want 1100", {bus_err, halted, illegal, mem_req});
    end
    ready_mode = 2'd0;
  endtask

  task automatic test_misalign();
    int reqs;
    prog = {32'h8C01_0002};  // lw $1,2($0)
    boot();
    repeat (3) @(negedge clk);
    n_chk++; if (mem_req !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL mis_exec: req %b berr %b want 0 0", mem_req, bus_err);
    end
    @(negedge clk);
    n_chk++; if ({bus_err, halted, illegal} !== 3'b110) begin
      n_fail++; $display("FAIL mis_trap: berr/halt/ill %b want 110", {bus_err, halted, illegal});
    end
    reqs = 0;
    for (int c = 0; c < 8; c++) begin
      if (mem_req) reqs++;
      @(negedge clk);
    end
    n_chk++; if (reqs !== 0) begin
      n_fail++; $display("FAIL mis_no_req: %0d request cycles want 0", reqs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_prog();
    test_sw_lw();
    test_beq_zero();
    test_illegal();
    test_timeout();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
